pixel_align: RTL and testbench

Single-clock N-channel pixel aligner and combiner, successor to the two-camera combiner. Sits after the per-camera clock-domain crossings. Buffers each channel in a small register FIFO, discards data until every channel is at a start-of-frame, then emits one word from all channels together under a valid/ready handshake. Overflow and frame misalignment trigger a flush and resynchronisation, and raise a stretched error flag.

---
 rtl/pixel_align.sv | 248 ++++++++++++++++++++++++
 tb/tb_pixel_align.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_align.sv
// pixel_align: single-clock N-channel pixel aligner and combiner.
//
// Each channel feeds a small register FIFO holding {sof, data}. In SYNC,
// every channel whose head is not a start-of-frame is discarded until all
// heads are at a start-of-frame. In RUN, one word from every channel is
// combined into a single output word. Overflow or frame misalignment flushes
// all FIFOs, returns to SYNC and raises a stretched error flag.
//
// Optional feature macro: PIXEL_ALIGN_DROP_CNT_EN adds the drop_cnt port, a
// saturating count of channel-words dropped.
//
// Ports:
//   clk        single clock
//   rst        synchronous, active-high reset
//   in_valid   [CH]     per-channel write strobe (no back-pressure)
//   in_sof     [CH]     per-channel start-of-frame marker
//   in_data    [CH*DW]  channel c at [c*DW +: DW]
//   out_valid           combined word held in the output register
//   out_ready           consumer accepts the held word
//   out_sof             held word is the first word of a frame
//   out_data   [CH*DW]  combined word, same packing as in_data
//   ovf        [CH]     sticky per-channel overflow flags
//   error               stretched error indication
//   drop_cnt   [16]     (PIXEL_ALIGN_DROP_CNT_EN only) dropped-word count
//
// Output handshake: a word transfers on a clock edge where out_valid and
// out_ready are both high; while out_valid is high and out_ready low, out_sof
// and out_data hold stable; a new word may load in the same cycle the old one
// is accepted.

module pixel_align #(
    parameter int CH       = 2,
    parameter int DW       = 16,
    parameter int DEPTH    = 16,
    parameter int ERR_HOLD = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH-1:0]    in_valid,
    input  logic [CH-1:0]    in_sof,
    input  logic [CH*DW-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sof,
    output logic [CH*DW-1:0] out_data,
    output logic [CH-1:0]    ovf,
    output logic             error
`ifdef PIXEL_ALIGN_DROP_CNT_EN
    ,
    output logic [15:0]      drop_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = $clog2(ERR_HOLD + 1);

    typedef enum logic {ST_SYNC = 1'b0, ST_RUN = 1'b1} state_t;

    // r_state is the FSM state register; it is the point to probe when
    // debugging alignment behaviour.
    state_t r_state;
    state_t w_state_nxt;

    logic [DW:0]      r_mem [CH][DEPTH];
    logic [PW-1:0]    r_wr_ptr [CH];
    logic [PW-1:0]    r_rd_ptr [CH];
    logic             r_out_valid;
    logic             r_out_sof;
    logic [CH*DW-1:0] r_out_data;
    logic [CH-1:0]    r_ovf;
    logic [EW-1:0]    r_err_cnt;

    logic [CH-1:0]    w_full;
    logic [CH-1:0]    w_empty;
    logic [CH-1:0]    w_head_sof;
    logic [CH*DW-1:0] w_head_data;
    logic [CH-1:0]    w_ovf_ev;
    logic [CH-1:0]    w_pop;
    logic             w_any_ovf;
    logic             w_all_ne;
    logic             w_slot_free;
    logic             w_load;
    logic             w_misalign;
    logic             w_flush;

    // Per-channel FIFO status and head word.
    always_comb begin
        w_full      = '0;
        w_empty     = '0;
        w_head_sof  = '0;
        w_head_data = '0;
        w_ovf_ev    = '0;
        for (int c = 0; c < CH; c++) begin
            w_full[c]  = (r_wr_ptr[c][AW] != r_rd_ptr[c][AW]) &&
                         (r_wr_ptr[c][AW-1:0] == r_rd_ptr[c][AW-1:0]);
            w_empty[c] = (r_wr_ptr[c] == r_rd_ptr[c]);
            w_head_sof[c]           = r_mem[c][r_rd_ptr[c][AW-1:0]][DW];
            w_head_data[c*DW +: DW] = r_mem[c][r_rd_ptr[c][AW-1:0]][DW-1:0];
            // full is taken before any same-cycle pop, so this is always a loss
            w_ovf_ev[c] = in_valid[c] & w_full[c];
        end
    end

    assign w_any_ovf   = |w_ovf_ev;
    assign w_all_ne    = &(~w_empty);
    assign w_slot_free = !r_out_valid || out_ready;
    assign w_flush     = w_any_ovf | w_misalign;

    // Next-state and pop/load decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = '0;
        w_load      = 1'b0;
        w_misalign  = 1'b0;
        case (r_state)
            ST_SYNC: begin
                w_pop = ~w_empty & ~w_head_sof;
                if (w_all_ne && (&w_head_sof)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_all_ne && w_slot_free) begin
                    if ((&w_head_sof) || !(|w_head_sof)) begin
                        w_pop  = '1;
                        w_load = 1'b1;
                    end else begin
                        w_misalign  = 1'b1;
                        w_state_nxt = ST_SYNC;
                    end
                end
            end
            default: w_state_nxt = ST_SYNC;
        endcase
        // Overflow wins: the flush discards everything, so nothing is popped.
        if (w_any_ovf) begin
            w_pop       = '0;
            w_load      = 1'b0;
            w_state_nxt = ST_SYNC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FIFO storage and pointers. A flush also swallows same-cycle writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                r_wr_ptr[c] <= '0;
                r_rd_ptr[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (w_flush) begin
                    r_wr_ptr[c] <= '0;
                    r_rd_ptr[c] <= '0;
                end else begin
                    if (in_valid[c] && !w_full[c]) begin
                        r_mem[c][r_wr_ptr[c][AW-1:0]] <= {in_sof[c], in_data[c*DW +: DW]};
                        r_wr_ptr[c] <= r_wr_ptr[c] + 1'b1;
                    end
                    if (w_pop[c]) begin
                        r_rd_ptr[c] <= r_rd_ptr[c] + 1'b1;
                    end
                end
            end
        end
    end

    // Output register; a flush never touches it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_data  <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_sof   <= w_head_sof[0];
            r_out_data  <= w_head_data;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Sticky overflow flags and error stretcher (reload on every event).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf     <= '0;
            r_err_cnt <= '0;
        end else begin
            r_ovf <= r_ovf | w_ovf_ev;
            if (w_flush) begin
                r_err_cnt <= EW'(ERR_HOLD);
            end else if (r_err_cnt != '0) begin
                r_err_cnt <= r_err_cnt - 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sof   = r_out_sof;
    assign out_data  = r_out_data;
    assign ovf       = r_ovf;
    assign error     = (r_err_cnt != '0);

`ifdef PIXEL_ALIGN_DROP_CNT_EN
    logic [15:0]   r_drop_cnt;
    logic [31:0]   w_drop_num;
    logic [32:0]   w_drop_sum;
    logic [PW-1:0] w_occ;

    // Words lost this cycle: on a flush, every stored word plus any write
    // arriving that cycle; otherwise, the discards made while in SYNC.
    always_comb begin
        w_drop_num = '0;
        w_occ      = '0;
        for (int c = 0; c < CH; c++) begin
            w_occ = r_wr_ptr[c] - r_rd_ptr[c];
            if (w_flush) begin
                w_drop_num = w_drop_num + 32'(w_occ) + 32'(in_valid[c]);
            end else if (r_state == ST_SYNC) begin
                w_drop_num = w_drop_num + 32'(w_pop[c]);
            end
        end
    end

    assign w_drop_sum = {17'b0, r_drop_cnt} + {1'b0, w_drop_num};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop_sum > 33'h0_0000_FFFF) begin
            r_drop_cnt <= 16'hFFFF;
        end else begin
            r_drop_cnt <= w_drop_sum[15:0];
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_pixel_align.sv
// Testbench for pixel_align (CH=2, DW=16, DEPTH=4, ERR_HOLD=8).
// Expected output words go into exp_q as stimulus is driven; a monitor on
// the falling edge pops and compares each word the DUT hands over.
`timescale 1ns/1ps

module tb_pixel_align;
    localparam int CH       = 2;
    localparam int DW       = 16;
    localparam int DEPTH    = 4;
    localparam int ERR_HOLD = 8;
    localparam int W        = CH*DW + 1;

    logic             clk;
    logic             rst;
    logic [CH-1:0]    in_valid;
    logic [CH-1:0]    in_sof;
    logic [CH*DW-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_sof;
    logic [CH*DW-1:0] out_data;
    logic [CH-1:0]    ovf;
    logic             error;
`ifdef PIXEL_ALIGN_DROP_CNT_EN
    logic [15:0]      drop_cnt;
`endif

    pixel_align #(
        .CH(CH), .DW(DW), .DEPTH(DEPTH), .ERR_HOLD(ERR_HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_sof(in_sof),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sof(out_sof),
        .out_data(out_data),
        .ovf(ovf),
        .error(error)
`ifdef PIXEL_ALIGN_DROP_CNT_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] sb_head;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            check("sb_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                sb_head = exp_q.pop_front();
                check("sb_word", 64'({out_sof, out_data}), 64'(sb_head));
            end
        end
    end

    // Number of cycles error was high since last cleared.
    int err_cycles = 0;
    always @(negedge clk) begin
        if (error === 1'b1) err_cycles++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = '0;
        in_sof    = '0;
        in_data   = '0;
        out_ready = 1'b0;
        exp_q.delete();
        tick(2);
        rst = 1'b0;
    endtask

    task automatic drive(input logic [CH-1:0] v, input logic [CH-1:0] s,
                         input logic [CH*DW-1:0] d);
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        tick();
        in_valid = '0;
        in_sof   = '0;
    endtask

    task automatic push_exp(input logic s, input logic [CH*DW-1:0] d);
        exp_q.push_back({s, d});
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // A misalignment flushes and returns to SYNC. With twice=1 a second
    // misalignment follows as early as it can: writes at the flush edge are
    // lost, so re-sync, one aligned pop, and the next mixed head take the
    // event to 4 edges after the first.
    task automatic misalign_case(input bit twice);
        do_reset();
        out_ready = 1'b1;
        push_exp(1'b1, 32'h6000_5000);
        drive(2'b11, 2'b11, 32'h6000_5000);
        wait_drain("mis_pre_drain");
        tick(2);
        err_cycles = 0;
        drive(2'b11, 2'b01, 32'h6001_5001);
        tick();
        check("mis_error", 64'(error), 64'd1);
        check("mis_no_load", 64'(out_valid), 64'd0);
        if (twice) begin
            push_exp(1'b1, 32'h6002_5002);
            drive(2'b11, 2'b11, 32'h6002_5002);
            drive(2'b11, 2'b01, 32'h6003_5003);
        end
        tick(20);
        check(twice ? "mis2_err_len" : "mis_err_len", 64'(err_cycles),
              twice ? 64'(ERR_HOLD + 4) : 64'(ERR_HOLD));
        // Flushed FIFOs: a fresh aligned frame comes out cleanly.
        push_exp(1'b1, 32'h6100_5100);
        drive(2'b11, 2'b11, 32'h6100_5100);
        wait_drain("mis_post_drain");
    endtask

    // ---------------- test sequence ----------------
`ifdef PIXEL_ALIGN_DROP_CNT_EN
    logic [15:0] drop_before;
`endif

    initial begin
        // Reset and idle
        do_reset();
        check("rst_sof", 64'(out_sof), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
`ifdef PIXEL_ALIGN_DROP_CNT_EN
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
        for (int i = 0; i < 20; i++) begin
            check("idle_valid", 64'(out_valid), 64'd0);
            check("idle_error", 64'(error), 64'd0);
            check("idle_ovf", 64'(ovf), 64'd0);
            tick();
        end

        // Frame alignment: ch0 has two leading non-sof words
        do_reset();
        out_ready  = 1'b1;
        err_cycles = 0;
        push_exp(1'b1, 32'h0200_0100);
        push_exp(1'b0, 32'h0201_0101);
        drive(2'b11, 2'b10, 32'h0200_0001);
        drive(2'b11, 2'b00, 32'h0201_0002);
        drive(2'b01, 2'b01, 32'h0000_0100);
        drive(2'b01, 2'b00, 32'h0000_0101);
        wait_drain("align_drain");
        tick(3);
        check("align_no_error", 64'(err_cycles), 64'd0);
`ifdef PIXEL_ALIGN_DROP_CNT_EN
        check("align_drop_cnt", 64'(drop_cnt), 64'd2);
`endif

        // Back-pressure: 3 aligned words, consumer stalled
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_exp(i == 0, {16'(16'h2000 + i), 16'(16'h1000 + i)});
            drive(2'b11, (i == 0) ? 2'b11 : 2'b00, {16'(16'h2000 + i), 16'(16'h1000 + i)});
        end
        // first word written 2 edges ago: SYNC->RUN, then load
        check("bp_latency", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_word", 64'({out_sof, out_data}), 64'({1'b1, 32'h2000_1000}));
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp_stream_valid", 64'(out_valid), 64'd1);
            tick();
        end
        check("bp_stream_end", 64'(out_valid), 64'd0);
        wait_drain("bp_drain");

        // Overflow on ch0 with a word held in the output register
        do_reset();
        out_ready  = 1'b0;
        err_cycles = 0;
`ifdef PIXEL_ALIGN_DROP_CNT_EN
        drop_before = drop_cnt;
`endif
        push_exp(1'b1, 32'h4000_3000);
        drive(2'b11, 2'b11, 32'h4000_3000);
        for (int i = 1; i <= 5; i++) begin
            drive(2'b01, 2'b00, {16'h0000, 16'(16'h3000 + i)});
        end
        check("ovf_flag", 64'(ovf), 64'd1);
        check("ovf_error", 64'(error), 64'd1);
`ifdef PIXEL_ALIGN_DROP_CNT_EN
        check("ovf_drop_grew", 64'(drop_cnt > drop_before), 64'd1);
`endif
        tick(12);
        check("ovf_err_len", 64'(err_cycles), 64'(ERR_HOLD));
        check("ovf_hold_valid", 64'(out_valid), 64'd1);
        check("ovf_hold_word", 64'({out_sof, out_data}), 64'({1'b1, 32'h4000_3000}));
        out_ready = 1'b1;
        wait_drain("ovf_drain");
        // Back in SYNC: a non-sof word is discarded, the sof word comes out.
        drive(2'b11, 2'b00, 32'h4444_3333);
        push_exp(1'b1, 32'h4555_3555);
        drive(2'b11, 2'b11, 32'h4555_3555);
        wait_drain("ovf_resync_drain");
        tick(3);
        check("ovf_sticky", 64'(ovf), 64'd1);

        // Misalignment, single and repeated
        misalign_case(1'b0);
        misalign_case(1'b1);

        // Reset with a word held drops it
        do_reset();
        drive(2'b11, 2'b11, 32'h7000_7000);
        tick(3);
        check("midrst_held", 64'(out_valid), 64'd1);
        do_reset();
        check("midrst_valid", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
